paillier_plant_decryptor: RTL
=============================

# paillier_plant_decryptor

Plant-side counterpart of the encrypted inverted-pendulum controller. It accepts an encrypted control-input ciphertext and sequences an external `modexp_single_M` engine through Paillier decryption, m = L(c^lambda mod N²)·mu mod N. It then decodes m into a signed `data_length`-bit actuator command. It sits between the ciphertext link from the controller and the actuator driver.

## Interface
- `key_length`, 256, bit length of N.
- `data_length`, 32, width of the decoded command.
- `N`, 256-bit, Paillier modulus.
- `N_half`, (N+1)/2, boundary between positive and negative codes.
- `lambda`, 508-bit, private exponent.
- `N_inv_mont`, 508-bit, Montgomery-form inverse used for exact division by N.
- `mu_mont`, 256-bit, Montgomery-form mu.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ct_valid` in 1: ciphertext offered.
- `ct_ready` out 1: block can accept a ciphertext.
- `ct_data` in 528: ciphertext c, zero-extended.
- `exp_start` out 1: one-cycle start pulse to the engine.
- `exp_task` out 2: engine task code.
- `exp_base` out 528: engine base operand.
- `exp_exponent` out 528: engine exponent/multiplier operand.
- `exp_done` in 1: engine completion pulse.
- `exp_out` in 528: engine result.
- `u_valid` out 1: one-cycle pulse, decoded command available.
- `u_data` out `data_length`: signed two's-complement command.
- `err` out 1: qualifies `u_valid`; the transaction was malformed or saturated.

## Operation
States: IDLE, POW_START, POW_WAIT, DIV_START, DIV_WAIT, MUL_START, MUL_WAIT.

- **IDLE**
  - `ct_ready`=1.
  - On `ct_valid`&`ct_ready`: capture `ct_data` into `c_reg`, clear the error flag, go to POW_START.
- **POW_START**
  - `exp_start`=1, `exp_task`=2'b00, base=`c_reg`, exponent=`lambda`.
  - Go to POW_WAIT.
- **POW_WAIT**
  - On `exp_done`: `acc` <= `exp_out`−1 (the L-function numerator), go to DIV_START.
  - If `exp_out`==0, set the error flag; the subtraction wraps to all-ones and the sequence continues.
- **DIV_START**
  - `exp_start`=1, task 2'b10, base=`acc`, exponent=`N_inv_mont`.
  - Go to DIV_WAIT.
- **DIV_WAIT**
  - On `exp_done`: `acc` <= `exp_out`, go to MUL_START.
- **MUL_START**
  - `exp_start`=1, task 2'b11, base=`acc`, exponent=`mu_mont`.
  - Go to MUL_WAIT.
- **MUL_WAIT**
  - On `exp_done`: decode m=`exp_out`[key_length-1:0], register `u_data`/`err`, pulse `u_valid`, go to IDLE.

Operand hold:
- `exp_task`, `exp_base` and `exp_exponent` are held stable from each START cycle through the matching done.
- In IDLE they drive 0.

Signed decode:
- m < `N_half`: value = +m.
- m ≥ `N_half`: value = −(N−m). The subtraction is `key_length` bits wide, with no overflow.

Ignored inputs:
- `exp_done` is ignored in IDLE and in START states.
- `ct_valid` is ignored outside IDLE.

## Timing
- Reset values:
  - `ct_ready`=0 while `rst` is high.
  - `exp_start`=0, `exp_task`=0, `exp_base`=0, `exp_exponent`=0.
  - `u_valid`=0, `u_data`=0, `err`=0.
  - State goes to IDLE; `ct_ready`=1 in the first cycle after `rst` falls.
- Accept at cycle T → first `exp_start` at T+1.
- Done at cycle D → next `exp_start` at D+1.
- Final done at D3 → `u_valid`=1 at D3+1, and `ct_ready`=1 at D3+1.
  - A ciphertext presented at D3+1 is accepted at D3+1, back-to-back.
- `u_data` and `err` hold their values until the next `u_valid`.
- Total latency is 3 engine latencies + 4 cycles.
- Reset mid-operation abandons the transaction with no `u_valid`. The engine shares `rst`, so no stale done is expected; a stray done arriving in IDLE is ignored.

## Configuration
- `DEC_SATURATE_EN` defined:
  - A positive value > 2^(data_length−1)−1 clamps to 0x7FFFFFFF.
  - A negative value < −2^(data_length−1) clamps to 0x80000000.
  - Either clamp sets `err`.
- `DEC_SATURATE_EN` undefined:
  - `u_data` is the low `data_length` bits of the signed value, truncated.
  - `err` reflects only the `exp_out`==0 condition.
- In both builds, the `exp_out`==0 error forces `u_data`=0.

## Test plan
- **Reset:** hold `rst` for 3 cycles mid-stream → `ct_ready`, `exp_start`, `u_valid` and `err` all 0; `ct_ready`=1 in the cycle after release.
- **Positive command:** engine model with 5-cycle latency returning m=0x25 at the last step → task sequence 00/10/11 with exponents `lambda`/`N_inv_mont`/`mu_mont`, `u_data`=0x00000025, `err`=0, `u_valid` exactly one cycle, at D3+1.
- **Negative command:** last step returns N−5 → `u_data`=0xFFFFFFFB, `err`=0.
- **Out-of-range command:**
  - Last step returns 2^40 → with the macro `u_data`=0x7FFFFFFF, `err`=1; without it `u_data`=0x00000000, `err`=0.
  - Last step returns N−2^40 → with the macro `u_data`=0x80000000, `err`=1.
- **Handshake:** hold `ct_valid` high continuously with two ciphertexts → the first is accepted at T; the second is not accepted until D3+1, the same cycle as the first `u_valid`.
- **Error and abort:**
  - POW step returns 0 → `u_data`=0, `err`=1.
  - Assert `rst` during DIV_WAIT, then inject `exp_done` → no `u_valid`, stays in IDLE.

Source files
------------

// File: rtl/paillier_plant_decryptor.sv
// Paillier decryption sequencer driving an external modexp engine; decodes m into a signed command.
// Optional build macro DEC_SATURATE_EN clamps out-of-range commands and flags them on err.
module paillier_plant_decryptor #(
    parameter int key_length = 256,
    parameter int data_length = 32,
    parameter logic [key_length-1:0] N = {4{64'hE3C1_5A7F_9B2D_4E61}},
    parameter logic [key_length-1:0] N_half = key_length'(({1'b0, N} + 1'b1) >> 1),
    parameter logic [2*key_length-5:0] lambda =
        {{7{64'h9E37_79B9_7F4A_7C15}}, 60'hABC_DEF0_1234_5678},
    parameter logic [2*key_length-5:0] N_inv_mont =
        {{7{64'h5851_F42D_4C95_7F2D}}, 60'h123_4567_89AB_CDEF},
    parameter logic [key_length-1:0] mu_mont = {4{64'hC2B2_AE3D_27D4_EB4F}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ct_valid,
    output logic                        ct_ready,
    input  logic [2*key_length+15:0]    ct_data,
    output logic                        exp_start,
    output logic [1:0]                  exp_task,
    output logic [2*key_length+15:0]    exp_base,
    output logic [2*key_length+15:0]    exp_exponent,
    input  logic                        exp_done,
    input  logic [2*key_length+15:0]    exp_out,
    output logic                        u_valid,
    output logic [data_length-1:0]      u_data,
    output logic                        err
);
    localparam int W = 2*key_length+16;

    typedef enum logic [2:0] {
        IDLE, POW_START, POW_WAIT, DIV_START, DIV_WAIT, MUL_START, MUL_WAIT
    } state_t;

    state_t state, state_next;
    logic [W-1:0] c_reg, acc;
    logic err_flag;
    logic [key_length-1:0] m;
    logic neg;
    logic [data_length-1:0] dec_data;
    logic dec_err;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        ct_ready     = 1'b0;
        exp_start    = 1'b0;
        exp_task     = 2'b00;
        exp_base     = '0;
        exp_exponent = '0;
        unique case (state)
            IDLE: begin
                ct_ready = 1'b1;
                if (ct_valid) state_next = POW_START;
            end
            POW_START, POW_WAIT: begin
                exp_start    = (state == POW_START);
                exp_base     = c_reg;
                exp_exponent = W'(lambda);
                if (state == POW_START) state_next = POW_WAIT;
                else if (exp_done)      state_next = DIV_START;
            end
            DIV_START, DIV_WAIT: begin
                exp_start    = (state == DIV_START);
                exp_task     = 2'b10;
                exp_base     = acc;
                exp_exponent = W'(N_inv_mont);
                if (state == DIV_START) state_next = DIV_WAIT;
                else if (exp_done)      state_next = MUL_START;
            end
            MUL_START, MUL_WAIT: begin
                exp_start    = (state == MUL_START);
                exp_task     = 2'b11;
                exp_base     = acc;
                exp_exponent = W'(mu_mont);
                if (state == MUL_START) state_next = MUL_WAIT;
                else if (exp_done)      state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs stay quiet for the whole reset window, not just after the first edge.
        if (rst) begin
            ct_ready     = 1'b0;
            exp_start    = 1'b0;
            exp_task     = 2'b00;
            exp_base     = '0;
            exp_exponent = '0;
        end
    end

`ifdef DEC_SATURATE_EN
    localparam logic [key_length-1:0] POS_MAX = key_length'({(data_length-1){1'b1}});
    localparam logic [key_length-1:0] NEG_MAX = POS_MAX + 1'b1;
    logic [key_length-1:0] mag;
`endif

    always_comb begin
        m        = exp_out[key_length-1:0];
        neg      = (m >= N_half);
        dec_data = neg ? data_length'(m - N) : m[data_length-1:0];
        dec_err  = 1'b0;
`ifdef DEC_SATURATE_EN
        mag = neg ? (N - m) : m;
        if (!neg && mag > POS_MAX) begin
            dec_data = {1'b0, {(data_length-1){1'b1}}};
            dec_err  = 1'b1;
        end else if (neg && mag > NEG_MAX) begin
            dec_data = {1'b1, {(data_length-1){1'b0}}};
            dec_err  = 1'b1;
        end
`endif
        if (err_flag) begin
            dec_data = '0;
            dec_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_reg    <= '0;
            acc      <= '0;
            err_flag <= 1'b0;
            u_valid  <= 1'b0;
            u_data   <= '0;
            err      <= 1'b0;
        end else begin
            u_valid <= 1'b0;
            unique case (state)
                IDLE: if (ct_valid) begin
                    c_reg    <= ct_data;
                    err_flag <= 1'b0;
                end
                // A zero power result is malformed; the wrapped numerator is kept.
                POW_WAIT: if (exp_done) begin
                    acc <= exp_out - W'(1);
                    if (exp_out == '0) err_flag <= 1'b1;
                end
                DIV_WAIT: if (exp_done) acc <= exp_out;
                MUL_WAIT: if (exp_done) begin
                    u_valid <= 1'b1;
                    u_data  <= dec_data;
                    err     <= dec_err;
                end
                default: ;
            endcase
        end
    end
endmodule
